// File: rtl/perlane_tx_gearbox_if.sv
// Lane-side bundle between the per-lane scrambler and the TX gearbox.
// master = upstream driver of the 66b word stream, slave = gearbox.
interface perlane_tx_gearbox_if;
    logic         in_enable;
    logic [255:0] in_txdata;
    logic [7:0]   in_synchdr;
    logic         in_txdata_valid;
    logic         out_idle;
    logic [255:0] out_pmadata;
    logic         out_pmadata_valid;
    logic         out_ovf;

    modport master (
        output in_enable, in_txdata, in_synchdr, in_txdata_valid,
        input  out_idle, out_pmadata, out_pmadata_valid, out_ovf
    );

    modport slave (
        input  in_enable, in_txdata, in_synchdr, in_txdata_valid,
        output out_idle, out_pmadata, out_pmadata_valid, out_ovf
    );
endinterface

// File: rtl/perlane_tx_gearbox.sv
// Repacks four 66b blocks per cycle (264 bits) into 256-bit PMA words through a residual buffer.
// Optional sticky overflow detector: define PCS_TXGB_OVF_CHECK_EN.
module perlane_tx_gearbox (
    input  logic                 clk,
    input  logic                 reset_n,
    perlane_tx_gearbox_if.slave  lane
);

    logic [775:0] buf_r;
    logic [775:0] buf_nxt_s;
    logic [775:0] total_s;
    logic [9:0]   r_r;
    logic [9:0]   r_nxt_s;
    logic [9:0]   total_cnt_s;
    logic [263:0] word_s;
    logic         append_s;
    logic         emit_s;
    logic [255:0] pmadata_r;
    logic         valid_r;
    logic         idle_r;

    // Header sits in the LSBs of each 66b block so it goes out on the wire first.
    function automatic logic [263:0] pack_blocks(input logic [255:0] data, input logic [7:0] hdr);
        logic [263:0] w;
        w = 264'd0;
        for (int k = 0; k < 4; k++) begin
            w[66*k +: 66] = {data[64*k +: 64], hdr[2*k +: 2]};
        end
        return w;
    endfunction

    // Append the new word above the residual, then decide emission and next fill.
    always_comb begin
        word_s      = pack_blocks(lane.in_txdata, lane.in_synchdr);
        append_s    = lane.in_enable && lane.in_txdata_valid && (r_r <= 10'd512);
        total_s     = buf_r;
        total_cnt_s = r_r;
        buf_nxt_s   = buf_r;
        r_nxt_s     = r_r;
        if (append_s) begin
            // Bits above r_r are kept zero, so OR-ing the shifted word is enough.
            total_s     = buf_r | ({512'd0, word_s} << r_r);
            total_cnt_s = r_r + 10'd264;
        end else begin
            total_s     = buf_r;
            total_cnt_s = r_r;
        end
        emit_s = (total_cnt_s >= 10'd256);
        if (!lane.in_enable) begin
            buf_nxt_s = 776'd0;
            r_nxt_s   = 10'd0;
        end else if (emit_s) begin
            buf_nxt_s = {256'd0, total_s[775:256]};
            r_nxt_s   = total_cnt_s - 10'd256;
        end else begin
            buf_nxt_s = total_s;
            r_nxt_s   = total_cnt_s;
        end
    end

    // Residual buffer, fill count and registered PMA outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_r     <= 776'd0;
            r_r       <= 10'd0;
            pmadata_r <= 256'd0;
            valid_r   <= 1'b0;
            idle_r    <= 1'b0;
        end else begin
            buf_r   <= buf_nxt_s;
            r_r     <= r_nxt_s;
            valid_r <= lane.in_enable && emit_s;
            idle_r  <= (r_nxt_s >= 10'd248);
            if (lane.in_enable && emit_s) begin
                pmadata_r <= total_s[255:0];
            end else begin
                pmadata_r <= pmadata_r;
            end
        end
    end

    assign lane.out_pmadata       = pmadata_r;
    assign lane.out_pmadata_valid = valid_r;
    assign lane.out_idle          = idle_r;

`ifdef PCS_TXGB_OVF_CHECK_EN
    logic drop_s;
    logic ovf_r;

    assign drop_s = lane.in_enable && lane.in_txdata_valid && (r_r > 10'd512);

    // Sticky overflow flag; only reset_n clears it, lane disable does not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign lane.out_ovf = ovf_r;
`else
    assign lane.out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_perlane_tx_gearbox.sv
// Scoreboard bench for perlane_tx_gearbox: a bit-queue reference model predicts every output cycle.
module tb_perlane_tx_gearbox;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    perlane_tx_gearbox_if lane_if ();

    perlane_tx_gearbox dut (
        .clk     (clk),
        .reset_n (reset_n),
        .lane    (lane_if)
    );

    always #5 clk = ~clk;

`ifdef PCS_TXGB_OVF_CHECK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    typedef struct {
        logic         vld;
        logic         idle;
        logic         ovf;
        logic [255:0] word;
    } ctl_t;

    ctl_t         ctl_q[$];
    logic [255:0] data_q[$];
    bit           bitq[$];
    logic [255:0] last_m;
    logic         ovf_m;
    int           n_tests = 0;
    int           n_fail = 0;
    int           n_out = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Drive one cycle (called at negedge+1) and predict the outputs after the next edge.
    task automatic drive(input logic en, input logic vld, input logic [255:0] d, input logic [7:0] h);
        ctl_t e;
        logic [255:0] w;
        lane_if.in_enable       = en;
        lane_if.in_txdata_valid = vld;
        lane_if.in_txdata       = d;
        lane_if.in_synchdr      = h;
        if (!en) begin
            bitq.delete();
            e.vld  = 1'b0;
            e.idle = 1'b0;
        end else begin
            if (vld) begin
                if (bitq.size() <= 512) begin
                    for (int k = 0; k < 4; k++) begin
                        bitq.push_back(h[2*k]);
                        bitq.push_back(h[2*k+1]);
                        for (int i = 0; i < 64; i++) bitq.push_back(d[64*k+i]);
                    end
                end else begin
                    ovf_m = OVF_EXP;
                end
            end
            if (bitq.size() >= 256) begin
                for (int i = 0; i < 256; i++) w[i] = bitq.pop_front();
                last_m = w;
                data_q.push_back(w);
                e.vld = 1'b1;
            end else begin
                e.vld = 1'b0;
            end
            e.idle = (bitq.size() >= 248);
        end
        e.ovf  = ovf_m;
        e.word = last_m;
        ctl_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Monitor: compares each predicted cycle; pops a data word whenever the DUT presents one.
    initial begin
        ctl_t e;
        forever begin
            @(negedge clk);
            if (ctl_q.size() > 0) begin
                e = ctl_q.pop_front();
                chk("valid", {255'd0, lane_if.out_pmadata_valid}, {255'd0, e.vld});
                chk("idle", {255'd0, lane_if.out_idle}, {255'd0, e.idle});
                chk("ovf", {255'd0, lane_if.out_ovf}, {255'd0, e.ovf});
                if (lane_if.out_pmadata_valid) begin
                    n_out++;
                    if (data_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL data: got %h expected no word", lane_if.out_pmadata);
                    end else begin
                        chk("data", lane_if.out_pmadata, data_q.pop_front());
                    end
                end else begin
                    if (e.vld && data_q.size() > 0) void'(data_q.pop_front());
                    chk("hold", lane_if.out_pmadata, e.word);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] expw;
        logic i1, i2, cur, v;
        int first, n0;
        lane_if.in_enable       = 1'b0;
        lane_if.in_txdata_valid = 1'b0;
        lane_if.in_txdata       = 256'd0;
        lane_if.in_synchdr      = 8'd0;
        last_m = 256'd0;
        ovf_m  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_data", lane_if.out_pmadata, 256'd0);
        chk("rst_valid", {255'd0, lane_if.out_pmadata_valid}, 256'd0);
        chk("rst_idle", {255'd0, lane_if.out_idle}, 256'd0);
        chk("rst_ovf", {255'd0, lane_if.out_ovf}, 256'd0);
        reset_n = 1'b1;

        // First word: only header bit 0 of each block is set.
        drive(1'b1, 1'b1, 256'd0, 8'h55);
        expw = 256'd0;
        for (int k = 0; k < 4; k++) expw[66*k] = 1'b1;
        chk("first_word", lane_if.out_pmadata, expw);
        chk("first_valid", {255'd0, lane_if.out_pmadata_valid}, 256'd1);

        // Three-cycle valid gap at r=0, then resume.
        drive(1'b0, 1'b0, 256'd0, 8'd0);
        repeat (3) drive(1'b1, 1'b0, rnd256(), 8'($urandom));
        repeat (4) drive(1'b1, 1'b1, rnd256(), 8'($urandom));
        drive(1'b0, 1'b0, 256'd0, 8'd0);

        // Steady state: upstream answers each idle request one cycle late.
        n0 = n_out; first = 0; i1 = 1'b0; i2 = 1'b0;
        for (int k = 1; k <= 66; k++) begin
            cur = lane_if.out_idle;
            if (cur && first == 0) first = k;
            v = !(i1 && !i2);
            i2 = i1; i1 = cur;
            drive(1'b1, v, rnd256(), 8'($urandom));
        end
        drive(1'b1, 1'b0, 256'd0, 8'd0);
        chk("idle_first_cycle", 256'(first), 256'd32);
        chk("steady_out_count", 256'(n_out - n0), 256'd66);

        // Lane disable at r=128.
        repeat (16) drive(1'b1, 1'b1, rnd256(), 8'($urandom));
        drive(1'b0, 1'b1, rnd256(), 8'($urandom));
        chk("dis_valid", {255'd0, lane_if.out_pmadata_valid}, 256'd0);
        chk("dis_idle", {255'd0, lane_if.out_idle}, 256'd0);
        repeat (5) drive(1'b1, 1'b1, rnd256(), 8'($urandom));
        drive(1'b0, 1'b0, 256'd0, 8'd0);

        // Upstream ignores idle: input 66 arrives at r=520 and is dropped.
        repeat (65) drive(1'b1, 1'b1, rnd256(), 8'($urandom));
        chk("ovf_before", {255'd0, lane_if.out_ovf}, 256'd0);
        drive(1'b1, 1'b1, rnd256(), 8'($urandom));
        chk("ovf_after", {255'd0, lane_if.out_ovf}, {255'd0, OVF_EXP});
        repeat (5) drive(1'b1, 1'b1, rnd256(), 8'($urandom));
        drive(1'b0, 1'b0, 256'd0, 8'd0);

        // Randomized traffic: late idle response, extra gaps, occasional disable.
        i1 = 1'b0; i2 = 1'b0;
        for (int k = 0; k < 300; k++) begin
            cur = lane_if.out_idle;
            v = !(i1 && !i2) && ($urandom_range(0, 7) != 0);
            i2 = i1; i1 = cur;
            drive(($urandom_range(0, 63) != 0), v, rnd256(), 8'($urandom));
        end

        // Asynchronous reset mid-stream.
        repeat (10) drive(1'b1, 1'b1, rnd256(), 8'($urandom));
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_data", lane_if.out_pmadata, 256'd0);
        chk("mid_rst_valid", {255'd0, lane_if.out_pmadata_valid}, 256'd0);
        chk("mid_rst_idle", {255'd0, lane_if.out_idle}, 256'd0);
        chk("mid_rst_ovf", {255'd0, lane_if.out_ovf}, 256'd0);
        ctl_q.delete();
        data_q.delete();
        bitq.delete();
        last_m = 256'd0;
        ovf_m  = 1'b0;
        lane_if.in_txdata_valid = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        i1 = 1'b0; i2 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cur = lane_if.out_idle;
            v = !(i1 && !i2);
            i2 = i1; i1 = cur;
            drive(1'b1, v, rnd256(), 8'($urandom));
        end
        repeat (2) drive(1'b1, 1'b0, 256'd0, 8'd0);
        @(negedge clk);
        #1;
        chk("drain", 256'(ctl_q.size()), 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
